// File: rtl/uart_pkg.sv
// Shared UART definitions: symbol-sequencer states, parity modes and baud divisor math.
// Used by the transmitter now and the receiver later.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Rounded divisor so the bit time error stays within half a clock.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte_if.sv
// Valid/ready byte handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_byte_if #(
   parameter int DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
// clr restarts the count so a new frame always begins on a full symbol.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. All outputs, including the serial line, come straight from flops.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_byte_if.slave   bus,
   output logic            tx_busy,
   output logic            tx_line
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_byte: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_byte: STOP_BITS must be 1 or 2");
   end
   if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx_byte: PARITY must be 0, 1 or 2");
   end

   uart_state_e          state, state_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [2:0]           bit_cnt, bit_cnt_n;
   logic                 par_bit, par_bit_n;
   logic                 ready_q, ready_n;
   logic                 busy_n, line_n;
   logic                 accept, baud_tick;

   assign accept       = bus.tx_valid && ready_q;
   assign bus.tx_ready = ready_q;

   uart_baud_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .tick (baud_tick)
   );

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      par_bit_n = par_bit;
      ready_n   = ready_q;
      busy_n    = tx_busy;
      line_n    = tx_line;

      case (state)
         ST_IDLE: begin
            ready_n = 1'b1;
            busy_n  = 1'b0;
            line_n  = 1'b1;
            if (accept) begin
               shreg_n   = bus.tx_data;
               par_bit_n = (^bus.tx_data) ^ (PARITY == PARITY_ODD);
               bit_cnt_n = '0;
               state_n   = ST_START;
               line_n    = 1'b0;
               ready_n   = 1'b0;
               busy_n    = 1'b1;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               state_n = ST_DATA;
               line_n  = shreg[0];
               shreg_n = shreg >> 1;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_cnt_n = '0;
                  if (PARITY != PARITY_NONE) begin
                     state_n = ST_PARITY;
                     line_n  = par_bit;
                  end else begin
                     state_n = ST_STOP;
                     line_n  = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  line_n    = shreg[0];
                  shreg_n   = shreg >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) begin
               state_n = ST_STOP;
               line_n  = 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_tick) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_cnt_n = '0;
                  state_n   = ST_IDLE;
                  busy_n    = 1'b0;
                  ready_n   = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            line_n  = 1'b1;
         end
      endcase
   end

   // Reset drops any frame in flight and parks the line at idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
         ready_q <= 1'b0;
         tx_busy <= 1'b0;
         tx_line <= 1'b1;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         par_bit <= par_bit_n;
         ready_q <= ready_n;
         tx_busy <= busy_n;
         tx_line <= line_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte at CLKS_PER_BIT=4: four instances cover 8N1, 8E1, 8O1 and 8E2.
// Outputs are sampled on the falling edge; every symbol is checked on each of its four cycles.
module tb_uart_tx_byte;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [7:0] data_r [4];
   logic [3:0] valid_v;
   wire  [3:0] ready_v, busy_v, line_v;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_byte_if #(.DATA_BITS(8)) bus ();
      assign bus.tx_data  = data_r[g];
      assign bus.tx_valid = valid_v[g];
      assign ready_v[g]   = bus.tx_ready;

      uart_tx_byte #(
         .CLK_FREQ  (100),
         .BAUD_RATE (25),
         .DATA_BITS (8),
         .PARITY    ((g == 0) ? 0 : ((g == 2) ? 2 : 1)),
         .STOP_BITS ((g == 3) ? 2 : 1)
      ) dut (
         .clk     (clk),
         .rst     (rst),
         .bus     (bus),
         .tx_busy (busy_v[g]),
         .tx_line (line_v[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Offers byte b, waits (bounded) for the accept edge, then samples every cycle of nsym symbols.
   task automatic run_frame(input int idx, input logic [7:0] b, input int nsym, input bit hold_valid,
                            input logic [7:0] next_b, input bit poke, output logic [15:0] sym,
                            output bit steady, output bit busy_ok, output bit rdy_early,
                            output bit timed_out, output int acc_edge);
      int waited;
      waited = 0; timed_out = 0; steady = 1; busy_ok = 1; rdy_early = 0; sym = '0;
      data_r[idx]  = b;
      valid_v[idx] = 1'b1;
      while (ready_v[idx] !== 1'b1) begin
         if (waited == 200) begin
            timed_out = 1;
            break;
         end
         @(negedge clk);
         waited++;
      end
      acc_edge = cyc + 1;
      @(negedge clk);
      valid_v[idx] = hold_valid;
      data_r[idx]  = next_b;
      for (int s = 0; s < nsym; s++) begin
         for (int c = 0; c < 4; c++) begin
            if (c == 0) sym[s] = line_v[idx];
            else if (line_v[idx] !== sym[s]) steady = 0;
            if (ready_v[idx] !== 1'b0) rdy_early = 1;
            if (busy_v[idx] !== 1'b1) busy_ok = 0;
            if (poke && s == 3 && c == 1) begin
               data_r[idx]  = ~b;
               valid_v[idx] = 1'b1;
            end
            if (poke && s == 3 && c == 2) valid_v[idx] = hold_valid;
            @(negedge clk);
         end
      end
   endtask

   task automatic frame_checks(input string tag, input int idx, input logic [7:0] b, input int nsym,
                               input logic [15:0] exp_sym, input bit hold_valid,
                               input logic [7:0] next_b, input bit poke, output int acc_edge);
      logic [15:0] sym;
      bit steady, busy_ok, rdy_early, to;
      run_frame(idx, b, nsym, hold_valid, next_b, poke, sym, steady, busy_ok, rdy_early, to, acc_edge);
      check({tag, "_accept_timeout"}, 32'(to), 32'd0);
      check({tag, "_symbols"}, 32'(sym), 32'(exp_sym));
      check({tag, "_symbol_stable"}, 32'(steady), 32'd1);
      check({tag, "_busy_in_frame"}, 32'(busy_ok), 32'd1);
      check({tag, "_ready_early"}, 32'(rdy_early), 32'd0);
      check({tag, "_ready_end"}, 32'(ready_v[idx]), 32'd1);
      check({tag, "_busy_end"}, 32'(busy_v[idx]), 32'd0);
      check({tag, "_line_end"}, 32'(line_v[idx]), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         acc, prev;
      bit         idle_ok;
      logic [7:0] stream [41];
      logic [7:0] nb;

      rst     = 1'b1;
      valid_v = '0;
      for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
      data_r[0]  = 8'h55;
      valid_v[0] = 1'b1;

      // Reset held 3 cycles with a byte on offer: nothing may be accepted.
      repeat (3) begin
         @(negedge clk);
         check("rst_line", 32'(line_v[0]), 32'd1);
         check("rst_ready", 32'(ready_v[0]), 32'd0);
         check("rst_busy", 32'(busy_v[0]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(ready_v[0]), 32'd1);
      check("post_rst_busy", 32'(busy_v[0]), 32'd0);
      check("post_rst_line", 32'(line_v[0]), 32'd1);
      valid_v[0] = 1'b0;

      idle_ok = 1;
      repeat (20) begin
         @(negedge clk);
         if (line_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) idle_ok = 0;
      end
      check("idle_quiet", 32'(idle_ok), 32'd1);

      // Symbol vectors, bit 0 = start: 0xAB 8N1 -> 0,1,1,0,1,0,1,0,1,1.
      frame_checks("8n1_ab", 0, 8'hAB, 10, 16'h0356, 1'b0, 8'h00, 1'b0, acc);
      frame_checks("8e1_01", 1, 8'h01, 11, 16'h0602, 1'b0, 8'h00, 1'b0, acc);
      frame_checks("8e1_03", 1, 8'h03, 11, 16'h0406, 1'b0, 8'h00, 1'b0, acc);
      frame_checks("8o1_01", 2, 8'h01, 11, 16'h0402, 1'b0, 8'h00, 1'b0, acc);
      frame_checks("8e2_01", 3, 8'h01, 12, 16'h0E02, 1'b0, 8'h00, 1'b0, acc);

      // tx_data flipped and tx_valid pulsed mid-frame must not disturb anything.
      frame_checks("poke_ab", 0, 8'hAB, 10, 16'h0356, 1'b0, 8'h00, 1'b1, acc);
      idle_ok = 1;
      repeat (12) begin
         @(negedge clk);
         if (line_v[0] !== 1'b1 || busy_v[0] !== 1'b0) idle_ok = 0;
      end
      check("poke_no_extra_accept", 32'(idle_ok), 32'd1);

      // Reset during data bit 3 of 0xAB.
      data_r[0]  = 8'hAB;
      valid_v[0] = 1'b1;
      @(negedge clk);
      valid_v[0] = 1'b0;
      repeat (13) @(negedge clk);
      check("mid_data_bit2", 32'(line_v[0]), 32'd0);
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(busy_v[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_line", 32'(line_v[0]), 32'd1);
      check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
      check("mid_rst_ready", 32'(ready_v[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_release_ready", 32'(ready_v[0]), 32'd1);
      frame_checks("after_rst_cd", 0, 8'hCD, 10, 16'h039A, 1'b0, 8'h00, 1'b0, acc);

      // One board streamed with tx_valid held high throughout.
      for (int i = 0; i < 41; i++) stream[i] = 8'h00;
      stream[0]  = 8'h56;
      stream[1]  = 8'h78;
      stream[40] = 8'h12;
      prev = 0;
      for (int i = 0; i < 41; i++) begin
         nb = (i < 40) ? stream[i + 1] : 8'h00;
         frame_checks($sformatf("stream%0d", i), 0, stream[i], 10,
                      {6'b0, 1'b1, stream[i], 1'b0}, (i < 40), nb, 1'b0, acc);
         if (i > 0) check($sformatf("stream%0d_gap", i), 32'(acc - prev), 32'd41);
         prev = acc;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Byte-wide UART transmitter directly downstream of the nibble-packing serializer that streams the 324-bit Sudoku board as 41 bytes.
- Accepts one byte per valid/ready handshake and drives an asynchronous serial line.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
- Sits at the edge of the FPGA and feeds the host PC link.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- DATA_BITS, 8, data bits per frame (5..8).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- Derived localparam CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE. Elaboration error if CLKS_PER_BIT < 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to transmit; sampled only on the accept edge.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  transmitter can accept a byte this cycle (registered).
- tx_busy  out  1  frame in progress (registered).
- tx_line  out  1  serial output; idle level 1 (registered).

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. At a reset edge: tx_line=1, tx_ready=0, tx_busy=0, state=IDLE, all counters cleared.
- First edge after rst deasserts: tx_ready=1.
- Reset mid-frame aborts the frame. tx_line returns to 1 at that edge; the aborted byte is never resumed.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY=0.
- Accept: occurs at an edge where tx_valid && tx_ready. At that edge:
  - tx_data is latched into a shift register.
  - state goes to START; tx_line=0.
  - tx_ready=0, tx_busy=1.
  - Baud counter and bit counter are cleared.
- tx_valid while tx_ready=0 has no effect. The producer holds data until accepted.
- Changes to tx_data after the accept edge do not affect the frame in flight.
- Each symbol lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; the terminal count advances the symbol.
- START: 1 symbol of 0. Then DATA.
- DATA: DATA_BITS symbols, shift register bit 0 first, shifting right. The bit counter wraps to 0 after DATA_BITS-1. Next state is PARITY if PARITY≠0, else STOP.
- PARITY:
  - even mode: XOR of data bits.
  - odd mode: inverted XOR.
  - Computed from the latched byte.
- STOP: STOP_BITS symbols of 1.
- End of frame: at the terminal count of the last stop symbol, state=IDLE, tx_busy=0, tx_ready=1, tx_line stays 1.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, from the accept edge to the edge where tx_ready rises.
- Back-to-back: if tx_valid is held high, the next accept occurs 1 edge after tx_ready rises. Frame-to-frame period is exactly F+1 cycles; the extra cycle extends stop time.
- tx_line is glitch-free: driven only from a flop, never combinational.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - parity-mode constants PARITY_NONE/EVEN/ODD;
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE.
  The future uart_rx_byte reuses the package.
- One natural sub-module: uart_baud_tick.
  - Counter with clear input.
  - Emits a one-cycle tick at count CLKS_PER_BIT-1.
  - Shared later with the receiver.

Test Plan:
All scenarios use CLK_FREQ=100 and BAUD_RATE=25, so CLKS_PER_BIT=4.
- Reset: hold rst 3 cycles, tx_valid=1 -> during reset tx_line=1, tx_ready=0, no accept. tx_ready=1 on the first edge after release.
- 8N1 with 0xAB:
  - accept at edge k;
  - tx_line is 0,1,1,0,1,0,1,0,1,1 (start, data LSB first, stop), each held 4 cycles;
  - tx_ready rises at edge k+40.
- Parity: PARITY=1, byte 0x01 -> parity symbol 1, F=44. PARITY=2, same byte -> parity symbol 0. STOP_BITS=2 -> F=48, last 8 cycles high.
- Streaming: model a producer holding tx_valid continuously with 41 bytes 0x56,0x78,0x00…,0x12 (one Sudoku board as bytes from the upstream nibble packer) -> every byte decoded correctly by a bench line monitor, accepts exactly 41 cycles apart, no byte dropped or duplicated.
- Protocol robustness:
  - change tx_data and pulse tx_valid mid-frame -> frame content unchanged, no extra accept;
  - tx_valid low in IDLE -> tx_line stays 1 indefinitely.
- Reset mid-frame: assert rst during data bit 3 of 0xAB -> tx_line=1 at that edge, tx_busy=0. After release, the next byte 0xCD is sent as a clean, full 40-cycle frame.
